// File: rtl/next_pc_predictor_if.sv
// Fetch-side bundle of the next-PC predictor: current PC, EX resolution, prediction and statistics.
// No handshake; every field is a plain per-cycle level.
// The slave side is the predictor; the master side is the surrounding pipeline (or a bench).
interface next_pc_predictor_if;
  logic [31:0] pcCur;
  logic        exValid;
  logic        exIsJump;
  logic [31:0] exPc;
  logic        exTaken;
  logic [31:0] exTarget;
  logic        exPredTaken;
  logic [31:0] exPredTarget;
  logic [31:0] pcNext;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        flush;
  logic [31:0] branchCnt;
  logic [31:0] mispredCnt;

  modport master (
    output pcCur, exValid, exIsJump, exPc, exTaken, exTarget, exPredTaken, exPredTarget,
    input  pcNext, predTaken, predTarget, flush, branchCnt, mispredCnt
  );

  modport slave (
    input  pcCur, exValid, exIsJump, exPc, exTaken, exTarget, exPredTaken, exPredTarget,
    output pcNext, predTaken, predTarget, flush, branchCnt, mispredCnt
  );
endinterface

// File: rtl/next_pc_predictor.sv
// Next-PC selection with a direct-mapped BTB (2-bit counters), EX-stage redirect and statistics.
// Latency: lookup and redirect are combinational; table/counter updates land on the next posedge.
// Backpressure: none; one update per cycle, never stalls.
module next_pc_predictor #(
  parameter int ENTRIES = 16
) (
  input logic               clk,
  input logic               rstN,
  next_pc_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];
  logic [31:0]        branch_cnt;
  logic [31:0]        mispred_cnt;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [31:0]      seq_pc;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             mispredict;
  logic [31:0]      correct_pc;

  assign rd_idx = bus.pcCur[IDX_W+1:2];
  assign rd_tag = bus.pcCur[31:IDX_W+2];
  assign wr_idx = bus.exPc[IDX_W+1:2];
  assign wr_tag = bus.exPc[31:IDX_W+2];
  assign seq_pc = bus.pcCur + 32'd4;

  // Lookup and redirect selection; the table is read before any same-cycle update lands.
  always_comb begin
    rd_hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    wr_hit     = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
    mispredict = bus.exValid &&
                 ((bus.exTaken != bus.exPredTaken) ||
                  (bus.exTaken && (bus.exTarget != bus.exPredTarget)));
    correct_pc = bus.exTaken ? bus.exTarget : (bus.exPc + 32'd4);

    bus.predTaken  = rd_hit && ctr_mem[rd_idx][1];
    bus.predTarget = rd_hit ? target_mem[rd_idx] : seq_pc;
    bus.flush      = mispredict;

    if (mispredict) begin
      bus.pcNext = correct_pc;
    end else if (bus.predTaken) begin
      bus.pcNext = target_mem[rd_idx];
    end else begin
      bus.pcNext = seq_pc;
    end
  end

  // BTB training from the resolved EX instruction; a miss only allocates when taken.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= 2'b00;
      end
    end else if (bus.exValid) begin
      if (wr_hit) begin
        if (bus.exIsJump) begin
          ctr_mem[wr_idx]    <= 2'b11;
          target_mem[wr_idx] <= bus.exTarget;
        end else if (bus.exTaken) begin
          if (ctr_mem[wr_idx] != 2'b11) begin
            ctr_mem[wr_idx] <= ctr_mem[wr_idx] + 2'd1;
          end
          target_mem[wr_idx] <= bus.exTarget;
        end else if (ctr_mem[wr_idx] != 2'b00) begin
          ctr_mem[wr_idx] <= ctr_mem[wr_idx] - 2'd1;
        end
      end else if (bus.exTaken) begin
        valid[wr_idx]      <= 1'b1;
        tag_mem[wr_idx]    <= wr_tag;
        target_mem[wr_idx] <= bus.exTarget;
        ctr_mem[wr_idx]    <= bus.exIsJump ? 2'b11 : 2'b10;
      end
    end
  end

  // Saturating statistics: every resolved transfer, and those that were mispredicted.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (bus.exValid) begin
      if (branch_cnt != 32'hFFFF_FFFF) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

  assign bus.branchCnt  = branch_cnt;
  assign bus.mispredCnt = mispred_cnt;
endmodule
